// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_pkg
//  Description : Shared types and constants for the MIPS fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FULL  = 2'd1,
        DROP  = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : PC owner; fetches words over req/ack and hands them to decode
//                over valid/ready, with redirect flush and misalignment halt.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus_4,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        fault
);

    fetch_state_t state, state_n;
    logic [31:0]  pc, pc_n;
    logic [31:0]  pending, pending_n;
    logic [31:0]  instr_n, instr_pc_n;
    logic         valid_n, fault_n;
    logic [31:0]  resolved;

    // A redirect arriving alongside the DROP ack supersedes the stored target.
    assign resolved = redirect ? redirect_target : pending;

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        pending_n  = pending;
        instr_n    = instr;
        instr_pc_n = instr_pc;
        valid_n    = instr_valid;
        fault_n    = fault;
        case (state)
            FETCH: begin
                if (redirect) begin
                    if (misaligned(redirect_target)) fault_n = 1'b1;
                    if (imem_ack) begin
                        if (misaligned(redirect_target)) begin
                            state_n = HALT;
                        end else begin
                            pc_n    = redirect_target;
                            state_n = FETCH;
                        end
                    end else begin
                        pending_n = redirect_target;
                        state_n   = DROP;
                    end
                end else if (imem_ack) begin
                    instr_n    = imem_rdata;
                    instr_pc_n = pc;
                    valid_n    = 1'b1;
                    pc_n       = pc + 32'(INSTR_BYTES);
                    state_n    = FULL;
                end
            end
            FULL: begin
                if (redirect) begin
                    valid_n = 1'b0;
                    if (misaligned(redirect_target)) begin
                        fault_n = 1'b1;
                        state_n = HALT;
                    end else begin
                        pc_n    = redirect_target;
                        state_n = FETCH;
                    end
                end else if (instr_ready) begin
                    valid_n = 1'b0;
                    state_n = FETCH;
                end
            end
            DROP: begin
                if (redirect) begin
                    pending_n = redirect_target;
                    if (misaligned(redirect_target)) fault_n = 1'b1;
                end
                if (imem_ack) begin
                    if (fault_n || misaligned(resolved)) begin
                        state_n = HALT;
                    end else begin
                        pc_n    = resolved;
                        state_n = FETCH;
                    end
                end
            end
            default: begin
                valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            pending     <= 32'h0;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            pending     <= pending_n;
            instr       <= instr_n;
            instr_pc    <= instr_pc_n;
            instr_valid <= valid_n;
            fault       <= fault_n;
        end
    end

    // Request is gated by reset so an in-flight fetch is abandoned at once.
    assign imem_req  = !reset && (state == FETCH || state == DROP);
    assign imem_addr = pc;
    assign pc_plus_4 = instr_pc + 32'(INSTR_BYTES);

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Directed self-checking bench for fetch_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, imem_ack = 1'b0;
    logic [31:0] imem_addr, imem_rdata;
    logic        instr_valid, instr_ready = 1'b0;
    logic [31:0] instr, instr_pc, pc_plus_4;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        fault;

    logic        wrap_reset = 1'b1;
    logic        wrap_req, wrap_valid, wrap_fault;
    logic [31:0] wrap_addr, wrap_rdata, wrap_instr, wrap_instr_pc, wrap_pc_plus_4;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ 32'hA5A5_0000;
    assign wrap_rdata = wrap_addr ^ 32'hA5A5_0000;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .pc_plus_4(pc_plus_4),
        .redirect(redirect), .redirect_target(redirect_target),
        .fault(fault)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(wrap_reset),
        .imem_req(wrap_req), .imem_addr(wrap_addr),
        .imem_ack(1'b1), .imem_rdata(wrap_rdata),
        .instr_valid(wrap_valid), .instr_ready(1'b1),
        .instr(wrap_instr), .instr_pc(wrap_instr_pc), .pc_plus_4(wrap_pc_plus_4),
        .redirect(1'b0), .redirect_target(32'h0),
        .fault(wrap_fault)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        step();
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
        vectors++; if (instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr got %h exp 0", instr); end
        vectors++; if (instr_pc !== 32'h0) begin miscompares++; $display("FAIL reset_instr_pc got %h exp 0", instr_pc); end
        vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault got %b exp 0", fault); end
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req got %b exp 0", imem_req); end
        reset = 1'b0;
        imem_ack = 1'b1;
        instr_ready = 1'b1;
        #1;
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL first_req got req=%b addr=%h exp 1/0", imem_req, imem_addr); end
    endtask

    task automatic test_stream();
        for (int k = 0; k < 3; k++) begin
            step();
            vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * k)) begin miscompares++; $display("FAIL stream_pc[%0d] got v=%b pc=%h exp 1/%h", k, instr_valid, instr_pc, 4 * k); end
            vectors++; if (instr !== (32'(4 * k) ^ 32'hA5A5_0000)) begin miscompares++; $display("FAIL stream_instr[%0d] got %h", k, instr); end
            vectors++; if (pc_plus_4 !== 32'(4 * k + 4)) begin miscompares++; $display("FAIL stream_pc4[%0d] got %h exp %h", k, pc_plus_4, 4 * k + 4); end
            vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL stream_req_full[%0d] got %b exp 0", k, imem_req); end
            step();
            vectors++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'(4 * k + 4)) begin miscompares++; $display("FAIL stream_refetch[%0d] got v=%b req=%b addr=%h", k, instr_valid, imem_req, imem_addr); end
        end
        imem_ack = 1'b0;
        instr_ready = 1'b0;
    endtask

    task automatic test_wait_states();
        for (int k = 0; k < 3; k++) begin
            step();
            vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'hC || instr_valid !== 1'b0) begin miscompares++; $display("FAIL wait[%0d] got req=%b addr=%h v=%b exp 1/c/0", k, imem_req, imem_addr, instr_valid); end
        end
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'hC) begin miscompares++; $display("FAIL wait_deliver got v=%b pc=%h exp 1/c", instr_valid, instr_pc); end
        for (int k = 0; k < 4; k++) begin
            step();
            vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'hC || instr !== 32'hA5A5_000C || imem_req !== 1'b0) begin miscompares++; $display("FAIL stall[%0d] got v=%b pc=%h instr=%h req=%b", k, instr_valid, instr_pc, instr, imem_req); end
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        vectors++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h10) begin miscompares++; $display("FAIL stall_release got v=%b req=%b addr=%h exp 0/1/10", instr_valid, imem_req, imem_addr); end
    endtask

    task automatic test_redirect_drop();
        step();
        redirect = 1'b1;
        redirect_target = 32'h40;
        step();
        redirect = 1'b0;
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin miscompares++; $display("FAIL drop_addr_hold got req=%b addr=%h exp 1/10", imem_req, imem_addr); end
        imem_ack = 1'b1;
        step();
        vectors++; if (instr_valid !== 1'b0 || imem_addr !== 32'h40) begin miscompares++; $display("FAIL drop_discard got v=%b addr=%h exp 0/40", instr_valid, imem_addr); end
        step();
        vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr !== 32'hA5A5_0040) begin miscompares++; $display("FAIL drop_deliver got v=%b pc=%h instr=%h", instr_valid, instr_pc, instr); end
    endtask

    task automatic test_redirect_full();
        redirect = 1'b1;
        redirect_target = 32'h100;
        instr_ready = 1'b1;
        step();
        vectors++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin miscompares++; $display("FAIL full_redirect got v=%b req=%b addr=%h exp 0/1/100", instr_valid, imem_req, imem_addr); end
        redirect_target = 32'h200;
        step();
        vectors++; if (instr_valid !== 1'b0 || imem_addr !== 32'h200) begin miscompares++; $display("FAIL ack_redirect got v=%b addr=%h exp 0/200", instr_valid, imem_addr); end
        redirect = 1'b0;
        step();
        vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200) begin miscompares++; $display("FAIL ack_redirect_deliver got v=%b pc=%h exp 1/200", instr_valid, instr_pc); end
        step();
        imem_ack = 1'b0;
        vectors++; if (imem_addr !== 32'h204 || imem_req !== 1'b1) begin miscompares++; $display("FAIL post_redirect got req=%b addr=%h exp 1/204", imem_req, imem_addr); end
    endtask

    task automatic test_fault();
        redirect = 1'b1;
        redirect_target = 32'h102;
        step();
        redirect = 1'b0;
        vectors++; if (fault !== 1'b1 || imem_req !== 1'b1) begin miscompares++; $display("FAIL fault_drop got fault=%b req=%b exp 1/1", fault, imem_req); end
        imem_ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            vectors++; if (fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL halt[%0d] got fault=%b req=%b v=%b exp 1/0/0", k, fault, imem_req, instr_valid); end
        end
        imem_ack = 1'b0;
        #2 reset = 1'b1;
        #2;
        vectors++; if (fault !== 1'b0 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL async_reset got fault=%b req=%b v=%b exp 0/0/0", fault, imem_req, instr_valid); end
        reset = 1'b0;
        #1;
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL restart got req=%b addr=%h exp 1/0", imem_req, imem_addr); end
        imem_ack = 1'b1;
        step();
        vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'hA5A5_0000) begin miscompares++; $display("FAIL restart_deliver got v=%b pc=%h instr=%h", instr_valid, instr_pc, instr); end
    endtask

    task automatic test_wrap();
        wrap_reset = 1'b0;
        #1;
        vectors++; if (wrap_req !== 1'b1 || wrap_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_first got req=%b addr=%h exp 1/fffffffc", wrap_req, wrap_addr); end
        step();
        vectors++; if (wrap_valid !== 1'b1 || wrap_instr_pc !== 32'hFFFF_FFFC || wrap_pc_plus_4 !== 32'h0) begin miscompares++; $display("FAIL wrap_deliver got v=%b pc=%h pc4=%h", wrap_valid, wrap_instr_pc, wrap_pc_plus_4); end
        vectors++; if (wrap_instr !== 32'h5A5A_FFFC || wrap_fault !== 1'b0) begin miscompares++; $display("FAIL wrap_instr got %h fault=%b exp 5a5afffc/0", wrap_instr, wrap_fault); end
        step();
        vectors++; if (wrap_req !== 1'b1 || wrap_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_next got req=%b addr=%h exp 1/0", wrap_req, wrap_addr); end
    endtask

    initial begin
        #1;
        test_reset();
        test_stream();
        test_wait_states();
        test_redirect_drop();
        test_redirect_full();
        test_fault();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
